// File: rtl/fpu_align_pkg.sv
// Shared constants and S1 payload layout for the significand alignment shifter.
package fpu_align_pkg;

   localparam int WIDTH_DEF = 56;
   localparam int SHW_DEF   = 6;
   localparam int EXW_DEF   = 12;
   localparam int TAGW_DEF  = 4;

   typedef struct packed {
      logic [WIDTH_DEF-1:0] sig;
      logic [SHW_DEF-1:0]   sh;
      logic                 sat;
      logic [WIDTH_DEF-1:0] mask;
      logic [TAGW_DEF-1:0]  tag;
   } s1_payload_t;

endpackage

// File: rtl/HDecJ.sv
// Half decoder: thermometer mask with bit i set iff i < code.
module HDecJ #(
   parameter int N = 6
) (
   input  logic [N-1:0]      code,
   output logic [2**N-1:0]   mask
);

   localparam logic [2**N-1:0] ONES = {(2**N){1'b1}};

   assign mask = ~(ONES << code);

endmodule

// File: rtl/align_shift_sticky.sv
// Two-stage right shifter with sticky reduction for exponent alignment.
// S1 captures operand, clamped shift and shifted-out mask; S2 holds the result.
module align_shift_sticky
   import fpu_align_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SHW   = SHW_DEF,
   parameter int EXW   = EXW_DEF,
   parameter int TAGW  = TAGW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_sig,
   input  logic [EXW-1:0]   in_sh,
   input  logic [TAGW-1:0]  in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sig,
   output logic             out_sticky,
   output logic [TAGW-1:0]  out_tag
);

   localparam logic [EXW-1:0] WIDTH_EX = EXW'(WIDTH);

   s1_payload_t        s1_r;
   s1_payload_t        s1_next_s;
   logic               s1_valid_r;
   logic               s2_valid_r;
   logic [2**SHW-1:0]  dec_s;
   logic               unused_dec_s;
   logic               sat_s;
   logic               s1_load_s;
   logic               s2_load_s;
   logic               in_fire_s;
   logic [WIDTH-1:0]   shifted_s;
   logic               sticky_s;

   HDecJ #(.N(SHW)) u_hdec (
      .code (in_sh[SHW-1:0]),
      .mask (dec_s)
   );

   // Decoder bits above WIDTH can only be set when the shift is clamped anyway.
   assign unused_dec_s = ^dec_s;

   assign s2_load_s = s1_valid_r && (!s2_valid_r || out_ready);
   assign s1_load_s = !s1_valid_r || s2_load_s;
   assign in_ready  = s1_load_s && !rst;
   assign in_fire_s = in_valid && in_ready;
   assign sat_s     = (in_sh >= WIDTH_EX);
   assign out_valid = s2_valid_r;

   // Build the S1 payload, clamping oversize shifts to an all-ones mask.
   always_comb begin
      s1_next_s.sig = in_sig;
      s1_next_s.tag = in_tag;
      if (sat_s) begin
         s1_next_s.sh   = {SHW{1'b0}};
         s1_next_s.sat  = 1'b1;
         s1_next_s.mask = {WIDTH{1'b1}};
      end else begin
         s1_next_s.sh   = in_sh[SHW-1:0];
         s1_next_s.sat  = 1'b0;
         s1_next_s.mask = dec_s[WIDTH-1:0];
      end
   end

   assign shifted_s = s1_r.sat ? {WIDTH{1'b0}} : (s1_r.sig >> s1_r.sh);
   assign sticky_s  = |(s1_r.sig & s1_r.mask);

   // S1 register: valid follows the input whenever the stage is free to load.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_r       <= {$bits(s1_payload_t){1'b0}};
      end else begin
         if (s1_load_s) begin
            s1_valid_r <= in_valid;
         end
         if (in_fire_s) begin
            s1_r <= s1_next_s;
         end
      end
   end

   // S2 register: result data changes only when a new operand advances in.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_r <= 1'b0;
         out_sig    <= {WIDTH{1'b0}};
         out_sticky <= 1'b0;
         out_tag    <= {TAGW{1'b0}};
      end else begin
         if (!s2_valid_r || out_ready) begin
            s2_valid_r <= s1_valid_r;
         end
         if (s2_load_s) begin
            out_sig    <= shifted_s;
            out_sticky <= sticky_s;
            out_tag    <= s1_r.tag;
         end
      end
   end

endmodule

// File: tb/tb_align_shift_sticky.sv
// Self-checking bench for align_shift_sticky: directed table, latency,
// backpressure, mid-stream reset and random streaming against a scoreboard.
module tb_align_shift_sticky;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [55:0] in_sig;
   logic [11:0] in_sh;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [55:0] out_sig;
   logic        out_sticky;
   logic [3:0]  out_tag;

   always #5 clk = ~clk;

   align_shift_sticky dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sig     (in_sig),
      .in_sh      (in_sh),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sig    (out_sig),
      .out_sticky (out_sticky),
      .out_tag    (out_tag)
   );

   typedef struct {
      logic [55:0] sig;
      logic [11:0] sh;
      logic [55:0] exp_sig;
      logic        exp_sticky;
   } vec_t;

   typedef struct {
      logic [55:0] sig;
      logic        sticky;
      logic [3:0]  tag;
   } exp_t;

   exp_t        sbq[$];
   exp_t        next_exp;
   vec_t        tbl[15];
   int          n_vec = 0;
   int          n_err = 0;
   bit          accepted;
   bit          hold_pending = 1'b0;
   logic [55:0] held_sig;
   logic        held_sticky;
   logic [3:0]  held_tag;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [55:0] sig, input logic [11:0] sh, input logic [3:0] tag);
      exp_t e;
      e.sig = 56'd0;
      e.sticky = 1'b0;
      e.tag = tag;
      if (sh >= 12'd56) begin
         e.sticky = |sig;
      end else begin
         for (int i = 0; i < 56; i++) begin
            if (i < int'(sh)) e.sticky = e.sticky | sig[i];
            if (i + int'(sh) < 56) e.sig[i] = sig[i + int'(sh)];
         end
      end
      return e;
   endfunction

   task automatic drive(input logic [55:0] sig, input logic [11:0] sh, input logic [3:0] tag, input exp_t e);
      in_valid = 1'b1;
      in_sig   = sig;
      in_sh    = sh;
      in_tag   = tag;
      next_exp = e;
   endtask

   // One clock: inputs already set after a negedge; sample, then wait for next negedge.
   task automatic cycle();
      exp_t got;
      #1;
      accepted = 1'b0;
      if (rst) begin
         chk("rst_in_ready", in_ready, 0);
      end else begin
         chk("in_ready", in_ready, !(sbq.size() == 2 && !out_ready));
         if (hold_pending) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sig", out_sig, held_sig);
            chk("hold_sticky", out_sticky, held_sticky);
            chk("hold_tag", out_tag, held_tag);
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               chk("spurious_out", 1, 0);
            end else begin
               got = sbq.pop_front();
               chk("out_sig", out_sig, got.sig);
               chk("out_sticky", out_sticky, got.sticky);
               chk("out_tag", out_tag, got.tag);
            end
         end
         if (in_valid && in_ready) begin
            sbq.push_back(next_exp);
            accepted = 1'b1;
         end
         hold_pending = out_valid && !out_ready;
         held_sig     = out_sig;
         held_sticky  = out_sticky;
         held_tag     = out_tag;
      end
      @(negedge clk);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 10 && sbq.size() > 0; c++) cycle();
      chk("drain_empty", sbq.size(), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   sent;
      bit   offering;
      logic [63:0] r64;
      logic [55:0] rs;
      logic [11:0] rsh;

      tbl[0]  = '{56'h80_0000_0000_0001, 12'd4,     56'h08_0000_0000_0000, 1'b1};
      tbl[1]  = '{56'h00_0000_0000_00F0, 12'd4,     56'h00_0000_0000_000F, 1'b0};
      tbl[2]  = '{56'h00_0000_0000_00F0, 12'd0,     56'h00_0000_0000_00F0, 1'b0};
      tbl[3]  = '{56'h00_0000_0000_0001, 12'd56,    56'h0,                 1'b1};
      tbl[4]  = '{56'h00_0000_0000_0001, 12'hFFF,   56'h0,                 1'b1};
      tbl[5]  = '{56'h0,                 12'd56,    56'h0,                 1'b0};
      tbl[6]  = '{56'h0,                 12'hFFF,   56'h0,                 1'b0};
      tbl[7]  = '{56'hC0_0000_0000_0001, 12'd55,    56'h00_0000_0000_0001, 1'b1};
      tbl[8]  = '{56'h80_0000_0000_0000, 12'd55,    56'h00_0000_0000_0001, 1'b0};
      tbl[9]  = '{56'hFF_FFFF_FFFF_FFFF, 12'd1,     56'h7F_FFFF_FFFF_FFFF, 1'b1};
      tbl[10] = '{56'h12_3456_789A_BCDE, 12'd8,     56'h00_1234_5678_9ABC, 1'b1};
      tbl[11] = '{56'hAB_0000_0000_0000, 12'd57,    56'h0,                 1'b1};
      tbl[12] = '{56'h00_0000_0000_0100, 12'd8,     56'h00_0000_0000_0001, 1'b0};
      tbl[13] = '{56'h55_5555_5555_5555, 12'd63,    56'h0,                 1'b1};
      tbl[14] = '{56'h40_0000_0000_0000, 12'd54,    56'h00_0000_0000_0001, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_sig = 56'd0; in_sh = 12'd0; in_tag = 4'd0;
      @(negedge clk);
      cycle();
      cycle();
      rst = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sig", out_sig, 0);
      chk("rst_out_sticky", out_sticky, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("post_rst_in_ready", in_ready, 1);

      // Directed table at full throughput.
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         e.sig = tbl[i].exp_sig;
         e.sticky = tbl[i].exp_sticky;
         e.tag = 4'(i);
         drive(tbl[i].sig, tbl[i].sh, 4'(i), e);
         cycle();
         chk("tbl_accept", accepted, 1);
      end
      drain();

      // Latency: result visible two cycles after the operand is offered.
      e.sig = 56'h0F; e.sticky = 1'b0; e.tag = 4'hA;
      drive(56'hF0, 12'd4, 4'hA, e);
      cycle();
      in_valid = 1'b0;
      chk("lat_c1_valid", out_valid, 0);
      cycle();
      chk("lat_c2_valid", out_valid, 1);
      drain();

      // Backpressure: out_ready toggles 1010...
      sent = 0;
      for (int c = 0; c < 200 && (sent < 8 || sbq.size() > 0); c++) begin
         out_ready = (c % 2 == 0);
         if (sent < 8) begin
            rs  = 56'h11_1111_1111_1111 * 56'(sent + 1);
            rsh = 12'(sent * 7);
            drive(rs, rsh, 4'(sent), model(rs, rsh, 4'(sent)));
         end else begin
            in_valid = 1'b0;
         end
         cycle();
         if (accepted) sent++;
      end
      chk("bp_all_done", (sent == 8 && sbq.size() == 0), 1);
      drain();

      // Reset mid-stream with both stages full.
      out_ready = 1'b0;
      drive(56'hDEAD, 12'd3, 4'h1, model(56'hDEAD, 12'd3, 4'h1));
      cycle();
      drive(56'hBEEF, 12'd5, 4'h2, model(56'hBEEF, 12'd5, 4'h2));
      cycle();
      drive(56'hCAFE, 12'd2, 4'h3, model(56'hCAFE, 12'd2, 4'h3));
      cycle();
      chk("full_blocked", accepted, 0);
      chk("full_out_valid", out_valid, 1);
      in_valid = 1'b0;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      sbq.delete();
      hold_pending = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_out_sig", out_sig, 0);
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         cycle();
         chk("no_stale_out", out_valid, 0);
      end

      // Random stream against the reference model.
      sent = 0;
      offering = 1'b0;
      for (int c = 0; c < 40000 && sent < 10000; c++) begin
         out_ready = ($urandom_range(0, 9) < 7);
         if (!offering && $urandom_range(0, 9) < 8) begin
            r64 = {$urandom(), $urandom()};
            rs  = r64[55:0];
            if ($urandom_range(0, 9) == 0) rsh = 12'($urandom());
            else rsh = 12'($urandom_range(0, 60));
            drive(rs, rsh, 4'(sent), model(rs, rsh, 4'(sent)));
            offering = 1'b1;
         end else if (!offering) begin
            in_valid = 1'b0;
         end
         cycle();
         if (accepted) begin
            sent++;
            offering = 1'b0;
            in_valid = 1'b0;
         end
      end
      chk("rand_all_sent", sent, 10000);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
